// File: rtl/data_sync_pkg.sv
// ---------------------------------------------------------------------------
// data_sync_pkg
// Shared constants for the destination-side multi-cycle-path bus synchronizer
// and the matching source-side transmitter.
//   MODE_LEVEL  : the source raises bus_enable; a rising edge is one transfer
//   MODE_TOGGLE : every bus_enable transition is one transfer
// ---------------------------------------------------------------------------
package data_sync_pkg;

  localparam int MODE_LEVEL  = 0;
  localparam int MODE_TOGGLE = 1;

  function automatic bit legal_mode(input int mode);
    return (mode == MODE_LEVEL) || (mode == MODE_TOGGLE);
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// ---------------------------------------------------------------------------
// data_sync_ch
// One channel of the bus synchronizer: bus_enable synchronizer chain, event
// detect, holding register with valid/ready, toggle acknowledge and sticky
// overrun flag.
// Ports:
//   CLK, RST       destination clock, asynchronous active-low reset
//   unsync_bus     quasi-static source data (stable around the transfer)
//   bus_enable     source control line, asynchronous to CLK
//   sync_bus       captured data
//   enable_pulse   one-cycle strobe in the cycle new data first appears
//   sync_valid     holding register contains unconsumed data
//   sync_ready     consumer accepts data when sync_valid & sync_ready
//   bus_ack        toggles once per consumed word
//   overrun        sticky: a new word overwrote an unconsumed one
//   overrun_clr    synchronous clear of overrun (a simultaneous set wins)
// ---------------------------------------------------------------------------
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH     = 8,
  parameter int NUM_OF_STAGES = 2,
  parameter int MODE          = MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 sync_valid,
  input  logic                 sync_ready,
  output logic                 bus_ack,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  logic [NUM_OF_STAGES-1:0] sync_reg;
  logic                     edge_reg;
  logic                     event_det;
  logic                     consume;

  assign consume = sync_valid & sync_ready;

  generate
    if (MODE == MODE_TOGGLE) begin : g_toggle
      // After reset the chain and edge flop start at 0 while bus_enable may
      // already be high; that difference is a re-synchronization artefact,
      // not a transfer. Events stay masked until the chain and edge flop have
      // both been filled from the live input (NUM_OF_STAGES+1 edges).
      logic [NUM_OF_STAGES:0] prime_reg;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          prime_reg <= '0;
        end else begin
          prime_reg <= {prime_reg[NUM_OF_STAGES-1:0], 1'b1};
        end
      end

      assign event_det = prime_reg[NUM_OF_STAGES] &
                         (sync_reg[NUM_OF_STAGES-1] ^ edge_reg);
    end else begin : g_level
      assign event_det = sync_reg[NUM_OF_STAGES-1] & ~edge_reg;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_reg     <= '0;
      edge_reg     <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      sync_valid   <= 1'b0;
      bus_ack      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[NUM_OF_STAGES-2:0], bus_enable};
      edge_reg     <= sync_reg[NUM_OF_STAGES-1];
      enable_pulse <= event_det;

      if (event_det) begin
        sync_bus <= unsync_bus;
      end

      // A new word keeps valid high even when the old one is consumed on the
      // same edge; the ack below still reports that consumption.
      if (event_det) begin
        sync_valid <= 1'b1;
      end else if (consume) begin
        sync_valid <= 1'b0;
      end

      if (consume) begin
        bus_ack <= ~bus_ack;
      end

      // Overrun only when the previous word is lost: valid and not taken.
      if (event_det && sync_valid && !sync_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_sync_mc.sv
// ---------------------------------------------------------------------------
// data_sync_mc
// Multi-channel destination-side bus synchronizer. NUM_CH independent
// data_sync_ch instances; this level only slices the buses.
// Ports (channel c uses bit c of each control vector and bits
// [c*BUS_WIDTH +: BUS_WIDTH] of each data bus):
//   CLK, RST       destination clock, asynchronous active-low reset
//   unsync_bus     source data, all channels
//   bus_enable     per-channel source control lines
//   sync_bus       captured data, all channels
//   enable_pulse   per-channel one-cycle new-data strobe
//   sync_valid     per-channel unconsumed-data flag
//   sync_ready     per-channel consumer ready
//   bus_ack        per-channel toggle acknowledge to the source domain
//   overrun        per-channel sticky overrun flag
//   overrun_clr    per-channel synchronous overrun clear
// ---------------------------------------------------------------------------
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH     = 8,
  parameter int NUM_OF_STAGES = 2,
  parameter int NUM_CH        = 4,
  parameter int MODE          = MODE_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  input  logic [NUM_CH-1:0]           sync_ready,
  output logic [NUM_CH-1:0]           bus_ack,
  output logic [NUM_CH-1:0]           overrun,
  input  logic [NUM_CH-1:0]           overrun_clr
);

  generate
    if (NUM_OF_STAGES < 2) begin : g_bad_stages
      $error("data_sync_mc: NUM_OF_STAGES must be >= 2");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
      $error("data_sync_mc: NUM_CH must be >= 1");
    end
    if (!legal_mode(MODE)) begin : g_bad_mode
      $error("data_sync_mc: MODE must be MODE_LEVEL or MODE_TOGGLE");
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      data_sync_ch #(
        .BUS_WIDTH     (BUS_WIDTH),
        .NUM_OF_STAGES (NUM_OF_STAGES),
        .MODE          (MODE)
      ) u_ch (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH]),
        .bus_enable   (bus_enable[gi]),
        .sync_bus     (sync_bus[gi*BUS_WIDTH +: BUS_WIDTH]),
        .enable_pulse (enable_pulse[gi]),
        .sync_valid   (sync_valid[gi]),
        .sync_ready   (sync_ready[gi]),
        .bus_ack      (bus_ack[gi]),
        .overrun      (overrun[gi]),
        .overrun_clr  (overrun_clr[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_data_sync_mc.sv
// ---------------------------------------------------------------------------
// tb_data_sync_mc
// Two instances: d0 is MODE 0 (level) with 2 stages, d1 is MODE 1 (toggle)
// with 3 stages. Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_data_sync_mc;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  logic [31:0] ub0 = '0, sb0, ub1 = '0, sb1;
  logic [3:0]  be0 = '0, rdy0 = '0, clr0 = '0, ep0, sv0, ack0, ov0;
  logic [3:0]  be1 = '0, rdy1 = '0, clr1 = '0, ep1, sv1, ack1, ov1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.BUS_WIDTH(8), .NUM_OF_STAGES(2), .NUM_CH(4), .MODE(0)) d0 (
    .CLK(CLK), .RST(RST), .unsync_bus(ub0), .bus_enable(be0), .sync_bus(sb0),
    .enable_pulse(ep0), .sync_valid(sv0), .sync_ready(rdy0), .bus_ack(ack0),
    .overrun(ov0), .overrun_clr(clr0)
  );

  data_sync_mc #(.BUS_WIDTH(8), .NUM_OF_STAGES(3), .NUM_CH(4), .MODE(1)) d1 (
    .CLK(CLK), .RST(RST), .unsync_bus(ub1), .bus_enable(be1), .sync_bus(sb1),
    .enable_pulse(ep1), .sync_valid(sv1), .sync_ready(rdy1), .bus_ack(ack1),
    .overrun(ov1), .overrun_clr(clr1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d0 sync_bus"}, sb0, 32'h0);
    check({tag, " d0 flags"}, 32'({ep0, sv0, ack0, ov0}), 32'h0);
    check({tag, " d1 sync_bus"}, sb1, 32'h0);
    check({tag, " d1 flags"}, 32'({ep1, sv1, ack1, ov1}), 32'h0);
  endtask

  // Channel-2 vectors for d0, one row per clock.
  // ctl = {bus_enable, sync_ready, overrun_clr}; flg = {enable_pulse, sync_valid, bus_ack, overrun}
  typedef struct {
    logic [2:0] ctl;
    logic [7:0] ub;
    logic [7:0] sb;
    logic [3:0] flg;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  initial begin
    int cnt0;
    int cnt1;

    vecs[0]  = '{3'b100, 8'h5A, 8'h00, 4'b0000};
    vecs[1]  = '{3'b100, 8'h5A, 8'h00, 4'b0000};
    vecs[2]  = '{3'b100, 8'h5A, 8'h5A, 4'b1100};  // first word captured
    vecs[3]  = '{3'b000, 8'h5A, 8'h5A, 4'b0100};
    vecs[4]  = '{3'b000, 8'hC3, 8'h5A, 4'b0100};
    vecs[5]  = '{3'b100, 8'hC3, 8'h5A, 4'b0100};
    vecs[6]  = '{3'b100, 8'hC3, 8'h5A, 4'b0100};
    vecs[7]  = '{3'b100, 8'hC3, 8'hC3, 4'b1101};  // overwrite -> overrun, no ack
    vecs[8]  = '{3'b101, 8'hC3, 8'hC3, 4'b0100};  // clear
    vecs[9]  = '{3'b000, 8'hC3, 8'hC3, 4'b0100};
    vecs[10] = '{3'b000, 8'hC3, 8'hC3, 4'b0100};
    vecs[11] = '{3'b100, 8'h77, 8'hC3, 4'b0100};
    vecs[12] = '{3'b100, 8'h77, 8'hC3, 4'b0100};
    vecs[13] = '{3'b101, 8'h77, 8'h77, 4'b1101};  // set wins over clear
    vecs[14] = '{3'b110, 8'h77, 8'h77, 4'b0011};  // consume: ack toggles, overrun sticky
    vecs[15] = '{3'b001, 8'h77, 8'h77, 4'b0010};
    vecs[16] = '{3'b000, 8'h77, 8'h77, 4'b0010};
    vecs[17] = '{3'b100, 8'h12, 8'h77, 4'b0010};
    vecs[18] = '{3'b100, 8'h12, 8'h77, 4'b0010};
    vecs[19] = '{3'b100, 8'h12, 8'h12, 4'b1110};
    vecs[20] = '{3'b000, 8'h12, 8'h12, 4'b0110};
    vecs[21] = '{3'b000, 8'h34, 8'h12, 4'b0110};
    vecs[22] = '{3'b100, 8'h34, 8'h12, 4'b0110};
    vecs[23] = '{3'b100, 8'h34, 8'h12, 4'b0110};
    vecs[24] = '{3'b110, 8'h34, 8'h34, 4'b1100};  // event + consume same edge
    vecs[25] = '{3'b100, 8'h34, 8'h34, 4'b0100};

    // ---------------- reset state ----------------
    tick();
    tick();
    check_all_zero("reset");
    RST = 1'b1;
    tick();

    // ---------------- MODE 0, ch0, 0xA5 ----------------
    ub0[7:0] = 8'hA5;
    be0[0]   = 1'b1;
    tick();
    tick();
    check("m0 no pulse at edge 2", 32'({ep0[0], sv0[0]}), 32'h0);
    tick();
    check("m0 sync_bus at edge 3", 32'(sb0[7:0]), 32'hA5);
    check("m0 pulse at edge 3", 32'(ep0[0]), 32'h1);
    check("m0 valid at edge 3", 32'(sv0[0]), 32'h1);
    $display("m0 transfer ch0 data=%h", sb0[7:0]);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("m0 held-high no pulse", 32'(ep0[0]), 32'h0);
    end
    rdy0[0] = 1'b1;
    tick();
    rdy0[0] = 1'b0;
    check("m0 valid drop after consume", 32'(sv0[0]), 32'h0);
    check("m0 ack after consume", 32'(ack0[0]), 32'h1);
    be0[0] = 1'b0;
    tick();
    tick();
    tick();

    // ---------------- multi-channel independence ----------------
    ub0[7:0]   = 8'h01;
    ub0[31:24] = 8'hFE;
    be0        = 4'b1001;
    tick();
    tick();
    check("mc no pulse at edge 2", 32'(ep0), 32'h0);
    tick();
    check("mc sync_bus", sb0, 32'hFE000001);
    check("mc pulses", 32'(ep0), 32'h9);
    check("mc valid", 32'(sv0), 32'h9);
    $display("mc transfer ch0=%h ch3=%h", sb0[7:0], sb0[31:24]);
    rdy0 = 4'b1001;
    tick();
    rdy0 = 4'b0000;
    be0  = 4'b0000;
    check("mc ack", 32'(ack0), 32'h8);
    check("mc valid cleared", 32'(sv0), 32'h0);
    tick();
    tick();
    tick();

    // ---------------- table: ch2 overrun / clear / simultaneous ----------------
    for (int v = 0; v < NVEC; v++) begin
      be0[2]     = vecs[v].ctl[2];
      rdy0[2]    = vecs[v].ctl[1];
      clr0[2]    = vecs[v].ctl[0];
      ub0[23:16] = vecs[v].ub;
      tick();
      $display("vec %0d ch2 sync_bus=%h flags=%b", v, sb0[23:16], {ep0[2], sv0[2], ack0[2], ov0[2]});
      check($sformatf("vec %0d sync_bus", v), 32'(sb0[23:16]), 32'(vecs[v].sb));
      check($sformatf("vec %0d flags", v), 32'({ep0[2], sv0[2], ack0[2], ov0[2]}), 32'(vecs[v].flg));
    end
    be0[2]  = 1'b0;
    rdy0[2] = 1'b0;
    clr0[2] = 1'b0;

    // ---------------- MODE 1, N=3, ch1 toggles ----------------
    rdy1[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] val;
      val = 8'(8'h11 * (k + 1));
      ub1[15:8] = val;
      be1[1]    = ~be1[1];
      tick();
      tick();
      tick();
      check($sformatf("m1 t%0d no pulse at edge 3", k), 32'(ep1[1]), 32'h0);
      tick();
      check($sformatf("m1 t%0d pulse at edge 4", k), 32'(ep1[1]), 32'h1);
      check($sformatf("m1 t%0d data", k), 32'(sb1[15:8]), 32'(val));
      check($sformatf("m1 t%0d valid", k), 32'(sv1[1]), 32'h1);
      $display("m1 transfer %0d ch1 data=%h", k, sb1[15:8]);
      tick();
      check($sformatf("m1 t%0d pulse width", k), 32'(ep1[1]), 32'h0);
      check($sformatf("m1 t%0d ack", k), 32'(ack1[1]), 32'((k + 1) % 2));
      for (int w = 0; w < 5; w++) tick();
    end
    check("m1 other channels quiet", 32'({ep1[3:2], ep1[0], sv1[3:2], sv1[0]}), 32'h0);
    rdy1[1] = 1'b0;

    // ---------------- reset mid-transfer ----------------
    ub0[7:0] = 8'h5C;
    be0[0]   = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check_all_zero("async reset");
    tick();
    tick();
    RST  = 1'b1;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt0 += int'(ep0[0]);
      cnt1 += int'(ep1[1]);
    end
    check("post-reset m0 pulse count", 32'(cnt0), 32'd1);
    check("post-reset m0 data", 32'(sb0[7:0]), 32'h5C);
    check("post-reset m1 pulse count", 32'(cnt1), 32'd0);
    check("post-reset m1 valid", 32'(sv1), 32'h0);

    // A genuine toggle after re-synchronization still transfers.
    ub1[15:8] = 8'h44;
    be1[1]    = 1'b0;
    tick();
    tick();
    tick();
    check("post-reset m1 no early pulse", 32'(ep1[1]), 32'h0);
    tick();
    check("post-reset m1 toggle pulse", 32'(ep1[1]), 32'h1);
    check("post-reset m1 toggle data", 32'(sb1[15:8]), 32'h44);
    $display("m1 post-reset transfer ch1 data=%h", sb1[15:8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sync_mc.md
# data_sync_mc

Multi-channel, destination-side multi-cycle-path bus synchronizer for the multi-clock communication system. Each of NUM_CH channels carries a quasi-static data bus plus a control line from a foreign clock domain. The control line passes through an NUM_OF_STAGES-flop synchronizer, and its event (rising edge or toggle, per MODE) captures the bus into the CLK domain. Unlike the single-channel pulse synchronizer, each channel adds a valid/ready holding stage, a sticky overrun flag and a toggle acknowledge returned to the source domain.

## Interface
Parameters:
- BUS_WIDTH, 8, data bits per channel
- NUM_OF_STAGES, 2, synchronizer depth; legal values ≥2
- NUM_CH, 4, number of independent channels; legal values ≥1
- MODE, 0, event detection: 0 = level/rising-edge (source raises bus_enable), 1 = toggle (each bus_enable transition is one transfer)

Ports:
- CLK  in  1  destination clock
- RST  in  1  asynchronous, active-low reset
- unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]
- bus_enable  in  NUM_CH  per-channel source control line (asynchronous to CLK)
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data, same channel slicing
- enable_pulse  out  NUM_CH  one-cycle strobe, high in the cycle new data first appears on sync_bus
- sync_valid  out  NUM_CH  holding register contains unconsumed data
- sync_ready  in  NUM_CH  consumer accepts data when sync_valid & sync_ready
- bus_ack  out  NUM_CH  toggles once per consumed word; fed back to the source domain
- overrun  out  NUM_CH  sticky: a new event arrived while the previous word was still unconsumed
- overrun_clr  in  NUM_CH  synchronous clear of overrun

## Operation
- Per channel: sync chain s[0..N-1] shifts bus_enable in every cycle. An edge flop e holds s[N-1] delayed by one cycle.
- Event (combinational):
  - MODE 0: s[N-1] & ~e
  - MODE 1: s[N-1] ^ e
- On event: sync_bus[c] <= unsync_bus[c]; enable_pulse[c] <= 1; sync_valid[c] <= 1. With no event, enable_pulse[c] <= 0 and sync_bus holds its value.
- Consume (sync_valid & sync_ready), no event: sync_valid <= 0; bus_ack toggles.
- Event while sync_valid=1 and sync_ready=0: data is overwritten, sync_valid stays 1, overrun <= 1, no ack toggle.
- Event and consume in the same cycle: the old word is consumed (ack toggles) and the new word is loaded. sync_valid stays 1. No overrun.
- overrun_clr and an overrun event in the same cycle: the set wins.
- Channels are fully independent; there is no cross-channel ordering or arbitration.
- unsync_bus is required to be stable from the bus_enable change until enable_pulse. This is a source obligation and is not checked.

## Timing
- Reset value of every flop and output is 0: s, e, sync_bus, enable_pulse, sync_valid, bus_ack, overrun.
- Latency: bus_enable changes before CLK edge 1. s[N-1] is set at edge N, and sync_bus, enable_pulse and sync_valid are asserted at edge N+1. That is N+1 edges, plus up to one extra edge of metastability uncertainty.
- enable_pulse is exactly 1 cycle wide per event.
- MODE 0: bus_enable held high produces a single event. Another event requires bus_enable low for ≥1 synchronized cycle.
- MODE 1: minimum spacing between source toggles is N+1 CLK cycles; closer toggles may merge and are lost.
- sync_valid drops the cycle after the handshake edge. bus_ack toggles on that same edge.
- Reset mid-transfer: all state clears immediately (asynchronously). A bus_enable level still high after reset release produces a new event in MODE 0, but not in MODE 1, because the chain re-synchronizes to the level.

## Structure
- Package data_sync_pkg holds localparams MODE_LEVEL=0 and MODE_TOGGLE=1, shared with the source-side transmitter.
- Sub-module data_sync_ch implements one channel (sync chain, edge detect, holding register, ack, overrun). data_sync_mc instantiates NUM_CH copies in a generate loop and handles bus slicing only.
- Elaboration check: NUM_OF_STAGES ≥2, NUM_CH ≥1, MODE ∈ {0,1}.

## Test plan
- MODE 0, N=2, ch0: unsync_bus=0xA5, raise bus_enable[0] → sync_bus[0]=0xA5 and enable_pulse[0]=1 for one cycle at edge 3; sync_valid[0]=1. Holding bus_enable high 20 cycles gives no further pulse.
- MODE 1, N=3: toggle bus_enable[1] three times, 10 cycles apart, with data 0x11/0x22/0x33 and sync_ready=1 → three pulses, each at edge 4 after its toggle. Data arrives in order and bus_ack[1] toggles 3 times.
- Overrun: sync_ready[2]=0, send 0x5A then 0xC3 → sync_bus[2]=0xC3, overrun[2]=1, bus_ack unchanged. overrun_clr[2] clears the flag the next cycle.
- Simultaneous event and consume: align sync_ready with the second event's capture edge → sync_valid stays 1, overrun=0, bus_ack toggles once, new data shown.
- Multi-channel independence: events on channels 0 and 3 in the same cycle with 0x01/0xFE → both captured in the same cycle; channels 1 and 2 stay 0.
- Reset mid-transfer: assert RST one cycle after bus_enable rises → all outputs 0 immediately. After release with bus_enable still high, MODE 0 gives one pulse and MODE 1 gives none.
